// File: rtl/jk_bank_sequencer.sv
// Bank of WIDTH JK flip-flops shared by two requesters over a 4-phase
// req/ack handshake. Round-robin arbitration picks a winner. The winner's
// masked JK operation is applied for one cycle. The synchronous preset
// overrides every bank update.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch the winner's J/K drive
// APPLY | J/K driven to the bank for exactly one cycle
// ACK   | ack of the granted requester high until its req is sampled low

module jk_bank_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] mask0,
    output logic             ack0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] mask1,
    output logic             ack1,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             gnt_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] bank_q, bank_d;
    logic [WIDTH-1:0] bank_n_q;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic             win_valid;
    logic             win_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;
    logic             gnt_req;

    // Arbitration, next state, and the registered J/K/ack drive.
    // The winner's op/mask are latched already encoded as the J/K drive.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        j_d       = '0;
        k_d       = '0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        win_valid = 1'b0;
        win_id    = 1'b0;
        sel_op    = 2'b00;
        sel_mask  = '0;
        gnt_req   = gnt_q ? req1 : req0;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    win_valid = 1'b1;
                    win_id    = ~gnt_q;
                end else if (req0) begin
                    win_valid = 1'b1;
                    win_id    = 1'b0;
                end else if (req1) begin
                    win_valid = 1'b1;
                    win_id    = 1'b1;
                end
                if (win_valid) begin
                    sel_op   = win_id ? op1 : op0;
                    sel_mask = win_id ? mask1 : mask0;
                    gnt_d    = win_id;
                    j_d      = sel_mask & {WIDTH{sel_op[1]}};
                    k_d      = sel_mask & {WIDTH{sel_op[0]}};
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = ACK;
            end
            ACK: begin
                if (gnt_req) begin
                    ack0_d = ~gnt_q;
                    ack1_d = gnt_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bank update: J/K are zero outside APPLY, so the bank holds there;
    // preset wins over any JK update on the same edge.
    always_comb begin
        bank_d = (j_q & ~bank_q) | (~k_q & bank_q);
        if (set) begin
            bank_d = '1;
        end
    end

    // State, grant, drive and bank registers; qbar is kept as its own register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;
            j_q      <= '0;
            k_q      <= '0;
            bank_q   <= '0;
            bank_n_q <= '1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            bank_q   <= bank_d;
            bank_n_q <= ~bank_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign j      = j_q;
    assign k      = k_q;
    assign q      = bank_q;
    assign qbar   = bank_n_q;
    assign busy   = (state_q != IDLE);
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer (WIDTH=8). Expected J/K/q per
// transaction are pushed when stimulus is queued. A negedge monitor checks
// the drive in APPLY and the bank when the ack rises.

module tb_jk_bank_sequencer;

    logic       clk;
    logic       reset;
    logic       set;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] mask0, mask1;
    logic       ack0, ack1;
    logic [7:0] j, k, q, qbar;
    logic       busy;
    logic       gnt_id;

    typedef struct {
        logic       id;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] q;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] model_q;
    int         n_checks;
    int         n_fail;
    int         bc;

    jk_bank_sequencer #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .set    (set),
        .req0   (req0),
        .op0    (op0),
        .mask0  (mask0),
        .ack0   (ack0),
        .req1   (req1),
        .op1    (op1),
        .mask1  (mask1),
        .ack1   (ack1),
        .j      (j),
        .k      (k),
        .q      (q),
        .qbar   (qbar),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference JK bank behaviour, bit by bit from the op table.
    function automatic logic [7:0] jk_next(input logic [7:0] cur, input logic [1:0] op, input logic [7:0] mask);
        logic [7:0] r;
        r = cur;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                case (op)
                    2'b00: r[i] = cur[i];
                    2'b01: r[i] = 1'b0;
                    2'b10: r[i] = 1'b1;
                    default: r[i] = ~cur[i];
                endcase
            end
        end
        return r;
    endfunction

    task automatic push_txn(input logic id, input logic [1:0] op, input logic [7:0] mask, input bit preset);
        sb_t e;
        e.id = id;
        e.j  = '0;
        e.k  = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                e.j[i] = (op == 2'b10) || (op == 2'b11);
                e.k[i] = (op == 2'b01) || (op == 2'b11);
            end
        end
        e.q = preset ? 8'hFF : jk_next(model_q, op, mask);
        model_q = e.q;
        sb.push_back(e);
    endtask

    // One full 4-phase handshake from one requester. hold = extra cycles req
    // stays high after ack is seen. preset pulses set on the edge ending APPLY.
    task automatic txn(input logic id, input logic [1:0] op, input logic [7:0] mask,
                       input int hold, input bit preset, output int busy_cnt);
        bit got;
        bit done;
        busy_cnt = 0;
        got  = 1'b0;
        done = 1'b0;
        if (id == 1'b0) begin
            op0 = op; mask0 = mask; req0 = 1'b1;
        end else begin
            op1 = op; mask1 = mask; req1 = 1'b1;
        end
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (preset) set = busy && !ack0 && !ack1;
            got = id ? ack1 : ack0;
        end
        if (!got) check_val("ack_timeout", 0, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            check_val("ack_hold", id ? ack1 : ack0, 1);
        end
        if (id == 1'b0) req0 = 1'b0;
        else            req1 = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            done = id ? !ack1 : !ack0;
        end
        if (!done) check_val("ack_release_timeout", 0, 1);
    endtask

    // Monitor: qbar, ack exclusivity, J/K drive and scoreboard pops on ack rise.
    initial begin
        logic p0, p1;
        logic [7:0] nq;
        sb_t e;
        p0 = 1'b0;
        p1 = 1'b0;
        forever begin
            @(negedge clk);
            nq = ~q;
            check_val("qbar", qbar, nq);
            check_val("ack_overlap", ack0 & ack1, 0);
            if (busy && !ack0 && !ack1) begin
                if (sb.size() == 0) begin
                    check_val("apply_unexpected", 1, 0);
                end else begin
                    check_val("apply_j", j, sb[0].j);
                    check_val("apply_k", k, sb[0].k);
                end
            end else begin
                check_val("j_idle", j, 0);
                check_val("k_idle", k, 0);
            end
            if ((ack0 && !p0) || (ack1 && !p1)) begin
                if (sb.size() == 0) begin
                    check_val("ack_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("ack_id", ack1, e.id);
                    check_val("gnt_id", gnt_id, e.id);
                    check_val("bank_q", q, e.q);
                end
            end
            p0 = ack0;
            p1 = ack1;
        end
    end

    initial begin
        bit got;
        n_checks = 0;
        n_fail   = 0;
        model_q  = 8'h00;
        reset = 1'b1;
        set   = 1'b0;
        req0  = 1'b0; op0 = 2'b00; mask0 = 8'h00;
        req1  = 1'b0; op1 = 2'b00; mask1 = 8'h00;
        repeat (2) @(negedge clk);
        check_val("rst_q", q, 8'h00);
        check_val("rst_qbar", qbar, 8'hFF);
        check_val("rst_ack0", ack0, 0);
        check_val("rst_ack1", ack1, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_gnt", gnt_id, 1);
        reset = 1'b0;
        @(negedge clk);

        // Set low nibble; req held one extra cycle gives 3 busy cycles.
        push_txn(1'b0, 2'b10, 8'h0F, 1'b0);
        txn(1'b0, 2'b10, 8'h0F, 1, 1'b0, bc);
        check_val("busy_cycles", bc, 3);

        // Toggle then clear from requester 1.
        push_txn(1'b1, 2'b11, 8'h3C, 1'b0);
        txn(1'b1, 2'b11, 8'h3C, 0, 1'b0, bc);
        push_txn(1'b1, 2'b01, 8'h03, 1'b0);
        txn(1'b1, 2'b01, 8'h03, 0, 1'b0, bc);
        check_val("q_after_clear", q, 8'h30);

        // Round-robin with both requesters continuously requesting.
        push_txn(1'b0, 2'b10, 8'h01, 1'b0);
        push_txn(1'b1, 2'b10, 8'h80, 1'b0);
        push_txn(1'b0, 2'b10, 8'h01, 1'b0);
        push_txn(1'b1, 2'b10, 8'h80, 1'b0);
        fork
            begin
                int b0;
                txn(1'b0, 2'b10, 8'h01, 0, 1'b0, b0);
                txn(1'b0, 2'b10, 8'h01, 0, 1'b0, b0);
            end
            begin
                int b1;
                txn(1'b1, 2'b10, 8'h80, 0, 1'b0, b1);
                txn(1'b1, 2'b10, 8'h80, 0, 1'b0, b1);
            end
        join
        check_val("rr_q", q, 8'hB1);

        // Preset on the edge ending APPLY of a clear-all.
        push_txn(1'b0, 2'b01, 8'hFF, 1'b1);
        txn(1'b0, 2'b01, 8'hFF, 0, 1'b1, bc);
        check_val("preset_set_low", set, 0);
        check_val("preset_idle", busy, 0);
        check_val("preset_q", q, 8'hFF);

        // Async reset while ack1 is high, between clock edges.
        push_txn(1'b1, 2'b10, 8'hF0, 1'b0);
        op1 = 2'b10; mask1 = 8'hF0; req1 = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = ack1;
        end
        if (!got) check_val("midack_timeout", 0, 1);
        #2 reset = 1'b1;
        #1;
        check_val("midack_ack1", ack1, 0);
        check_val("midack_busy", busy, 0);
        check_val("midack_gnt", gnt_id, 1);
        check_val("midack_q", q, 8'h00);
        check_val("midack_qbar", qbar, 8'hFF);
        @(negedge clk);
        reset   = 1'b0;
        req1    = 1'b0;
        model_q = 8'h00;
        @(negedge clk);

        // First simultaneous request after reset goes to requester 0.
        push_txn(1'b0, 2'b10, 8'h01, 1'b0);
        push_txn(1'b1, 2'b11, 8'h81, 1'b0);
        fork
            begin
                int b0;
                txn(1'b0, 2'b10, 8'h01, 0, 1'b0, b0);
            end
            begin
                int b1;
                txn(1'b1, 2'b11, 8'h81, 0, 1'b0, b1);
            end
        join
        check_val("post_rst_q", q, 8'h80);

        // Hold op with req held 5 extra cycles in ACK.
        push_txn(1'b0, 2'b00, 8'hFF, 1'b0);
        txn(1'b0, 2'b00, 8'hFF, 5, 1'b0, bc);
        check_val("hold_busy_cycles", bc, 7);
        check_val("hold_q", q, 8'h80);

        repeat (3) @(negedge clk);
        check_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Controller owning a bank of WIDTH JK flip-flops; two requesters share it through a 4-phase req/ack handshake with round-robin arbitration.
- Each granted request applies one masked JK operation (hold/clear/set/toggle) to the bank.
- A synchronous preset forces the whole bank to ones.
- Sits between control logic and status/flag registers built from the team's JK flip-flop cells.

Parameters:
WIDTH, 8, number of JK flip-flops in the bank (1..32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
set  input  1  synchronous preset: all bank bits to 1 at next rising edge
req0  input  1  requester 0 request (4-phase)
op0  input  2  requester 0 operation: 00 hold, 01 clear, 10 set, 11 toggle
mask0  input  WIDTH  requester 0 bit select (1 = bit affected)
ack0  output  1  requester 0 acknowledge
req1  input  1  requester 1 request
op1  input  2  requester 1 operation
mask1  input  WIDTH  requester 1 bit select
ack1  output  1  requester 1 acknowledge
j  output  WIDTH  J drive to the bank, nonzero only in APPLY
k  output  WIDTH  K drive to the bank, nonzero only in APPLY
q  output  WIDTH  bank state
qbar  output  WIDTH  complement of q, always equal to ~q
busy  output  1  high whenever state != IDLE
gnt_id  output  1  id of the current or most recent grant

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: q=0, qbar=all ones, ack0=ack1=0, j=k=0, busy=0, gnt_id=1 (so requester 0 wins the first tie), state IDLE.
- FSM states: IDLE, APPLY, ACK.
- IDLE:
  - No req: stay in IDLE.
  - One req high: grant it.
  - Both high: grant the requester != gnt_id (round-robin).
  - On grant: latch op/mask of the winner, set gnt_id, go to APPLY.
  - req changes after the latching edge are ignored until the next IDLE.
- APPLY (exactly one cycle):
  - Registered j/k outputs per bit i:
    - mask[i]=0: j=0, k=0.
    - mask[i]=1: op 00 gives j=0,k=0; op 01 gives j=0,k=1; op 10 gives j=1,k=0; op 11 gives j=1,k=1.
  - At the edge ending APPLY, each bit updates with JK semantics: 00 hold, 01 to 0, 10 to 1, 11 invert.
  - Go to ACK.
- ACK:
  - j=k=0. ack of the granted requester is high; the other ack stays 0.
  - Stay in ACK while the granted req is high.
  - When the granted req is sampled low: ack drops that same edge, go to IDLE.
- Latency: grant edge to bank update is 2 edges; ack visible the cycle after the update.
- Minimum transaction is 4 cycles (IDLE, APPLY, ACK, IDLE).
- A requester that deasserts req before grant is simply not granted; there is no abort once in APPLY or ACK.
- set:
  - Sampled every edge; highest priority on q.
  - set=1 forces q=all ones, overriding any APPLY update on the same edge. The APPLY operation is lost but the FSM still advances and acks normally.
- qbar is the registered complement of q, never derived combinationally.
- reset asserted mid-transaction: immediate return to reset values; the pending ack is never issued; requesters must re-request.
- Unused mask bits above WIDTH do not exist; no width extension.

Test Plan:
- Reset and basic op, WIDTH=8:
  - Assert reset mid-cycle -> q=0x00, qbar=0xFF, acks 0 immediately, with no clk edge needed.
  - req0, op0=10, mask0=0x0F -> j=0x0F, k=0x00 in APPLY; q=0x0F after APPLY; ack0 high until req0 drops; busy 1 for 3 cycles.
- Toggle and clear masking, starting from q=0x0F:
  - req1, op1=11, mask1=0x3C -> q=0x33.
  - Then op1=01, mask1=0x03 -> q=0x30; qbar=~q at every cycle.
- Round-robin: req0 and req1 held continuously with distinct set ops (mask 0x01 / 0x80) -> grants alternate 0,1,0,1 starting with 0; gnt_id toggles; acks never overlap.
- Preset collision:
  - set=1 on the edge ending APPLY of a clear-all (op 01, mask 0xFF) -> q=0xFF.
  - ack still issued, FSM returns to IDLE.
- Reset mid-ACK: assert reset while ack1 high -> ack1=0, busy=0, state IDLE, gnt_id=1; the next simultaneous request grants requester 0.
- Hold op and late req: op 00 with mask 0xFF -> q unchanged, full handshake completes; req held high 5 extra cycles in ACK -> ack stays high, no second APPLY.
